// File: rtl/char_fetch_arbiter.sv
// Round-robin arbiter sharing one synchronous glyph ROM between two requesters.
// Each grant fetches all 2**ROW_W rows of a character and streams them out with idx/owner/last tags.
module char_fetch_arbiter #(
  parameter int CODE_W   = 8,
  parameter int ROW_W    = 3,
  parameter int READ_LAT = 1
) (
  input  logic                    clka,
  input  logic                    rst,
  input  logic                    req0,
  input  logic [CODE_W-1:0]       code0,
  output logic                    gnt0,
  input  logic                    req1,
  input  logic [CODE_W-1:0]       code1,
  output logic                    gnt1,
  output logic [CODE_W+ROW_W-1:0] rom_addr,
  input  logic [7:0]              rom_data,
  output logic                    out_valid,
  output logic [7:0]              out_data,
  output logic [ROW_W-1:0]        out_idx,
  output logic                    out_owner,
  output logic                    out_last,
  output logic                    busy
);

  localparam logic [ROW_W-1:0]   LAST_ROW  = '1;
  localparam int                 DRAIN_W   = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state;
  logic [CODE_W-1:0]   code;
  logic [ROW_W-1:0]    row;
  logic [ROW_W-1:0]    next_row;
  logic                owner;
  logic                last_owner;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic                any_req;
  logic                pick1;
  logic [CODE_W-1:0]   win_code;

  // Tag shift register: stage s holds the tag of the address issued s+1 cycles ago.
  logic [READ_LAT-1:0]            vld_pipe;
  logic [READ_LAT-1:0]            own_pipe;
  logic [READ_LAT-1:0][ROW_W-1:0] idx_pipe;

  assign any_req  = req0 | req1;
  assign pick1    = (req0 && req1) ? ~last_owner : req1;
  assign win_code = pick1 ? code1 : code0;
  assign next_row = row + ROW_W'(1);

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      code       <= '0;
      row        <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      drain_cnt  <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rom_addr   <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            code       <= win_code;
            owner      <= pick1;
            last_owner <= pick1;
            gnt0       <= ~pick1;
            gnt1       <= pick1;
            row        <= '0;
            rom_addr   <= {win_code, {ROW_W{1'b0}}};
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (row == LAST_ROW) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            row      <= next_row;
            rom_addr <= {code, next_row};
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_END) begin
            state <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      own_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[0] <= (state == ISSUE);
      own_pipe[0] <= owner;
      idx_pipe[0] <= row;
      for (int s = 1; s < READ_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        own_pipe[s] <= own_pipe[s-1];
        idx_pipe[s] <= idx_pipe[s-1];
      end
    end
  end

  assign out_valid = vld_pipe[READ_LAT-1];
  assign out_owner = own_pipe[READ_LAT-1];
  assign out_idx   = idx_pipe[READ_LAT-1];
  assign out_last  = out_valid && (out_idx == LAST_ROW);
  assign out_data  = out_valid ? rom_data : 8'h00;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_char_fetch_arbiter.sv
// Drives a READ_LAT=1 and a READ_LAT=3 arbiter with the same request stream and
// checks every output, every cycle, against a burst-schedule model of the behaviour.
module tb_char_fetch_arbiter;

  localparam int NI = 2;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic       rst;
  logic       req0, req1;
  logic [7:0] code0, code1;

  logic        gnt0_w  [NI];
  logic        gnt1_w  [NI];
  logic        busy_w  [NI];
  logic        val_w   [NI];
  logic        last_w  [NI];
  logic        own_w   [NI];
  logic [10:0] addr_w  [NI];
  logic [7:0]  rdata_w [NI];
  logic [7:0]  data_w  [NI];
  logic [2:0]  idx_w   [NI];

  logic [7:0] rom1_q;
  logic [7:0] rom3_q [3];

  char_fetch_arbiter #(.CODE_W(8), .ROW_W(3), .READ_LAT(1)) u_lat1 (
    .clka(clka), .rst(rst),
    .req0(req0), .code0(code0), .gnt0(gnt0_w[0]),
    .req1(req1), .code1(code1), .gnt1(gnt1_w[0]),
    .rom_addr(addr_w[0]), .rom_data(rdata_w[0]),
    .out_valid(val_w[0]), .out_data(data_w[0]), .out_idx(idx_w[0]),
    .out_owner(own_w[0]), .out_last(last_w[0]), .busy(busy_w[0])
  );

  char_fetch_arbiter #(.CODE_W(8), .ROW_W(3), .READ_LAT(3)) u_lat3 (
    .clka(clka), .rst(rst),
    .req0(req0), .code0(code0), .gnt0(gnt0_w[1]),
    .req1(req1), .code1(code1), .gnt1(gnt1_w[1]),
    .rom_addr(addr_w[1]), .rom_data(rdata_w[1]),
    .out_valid(val_w[1]), .out_data(data_w[1]), .out_idx(idx_w[1]),
    .out_owner(own_w[1]), .out_last(last_w[1]), .busy(busy_w[1])
  );

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    return a[7:0] ^ {a[10:8], a[10:6]} ^ 8'h5A;
  endfunction

  // Behavioural ROMs with 1 and 3 cycles of read latency.
  always @(posedge clka) begin
    rom1_q    <= rom_fn(addr_w[0]);
    rom3_q[0] <= rom_fn(addr_w[1]);
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end
  assign rdata_w[0] = rom1_q;
  assign rdata_w[1] = rom3_q[2];

  int n_checks = 0;
  int n_pass   = 0;
  int t        = 0;

  int         lat   [NI] = '{1, 3};
  int         a_cyc [NI];
  bit         have  [NI];
  logic [7:0] mcode [NI];
  bit         mown  [NI];
  bit         mlast [NI];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, t);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      have[i]  = 1'b0;
      mlast[i] = 1'b1;
      a_cyc[i] = 0;
    end
  endtask

  // A burst granted for cycle A issues row k in A+k and delivers it in A+k+lat;
  // the block is busy from A through A+7+lat and samples requests again after that.
  task automatic model_check(input int i);
    int          d, e;
    bit          act, v;
    logic [10:0] ea;
    logic [2:0]  ei;
    string       p;
    p   = $sformatf("L%0d", lat[i]);
    d   = t - a_cyc[i];
    act = have[i] && (d <= 7 + lat[i]);
    e   = d - lat[i];
    v   = act && (e >= 0) && (e <= 7);
    ea  = 11'd0;
    if (have[i]) ea = {mcode[i], 3'((d > 7) ? 7 : d)};
    check({p, " busy"},      32'(busy_w[i]), 32'(act));
    check({p, " gnt0"},      32'(gnt0_w[i]), 32'(have[i] && d == 0 && !mown[i]));
    check({p, " gnt1"},      32'(gnt1_w[i]), 32'(have[i] && d == 0 && mown[i]));
    check({p, " rom_addr"},  32'(addr_w[i]), 32'(ea));
    check({p, " out_valid"}, 32'(val_w[i]),  32'(v));
    check({p, " out_last"},  32'(last_w[i]), 32'(v && e == 7));
    if (v) begin
      ei = 3'(e);
      check({p, " out_idx"},   32'(idx_w[i]),  32'(ei));
      check({p, " out_owner"}, 32'(own_w[i]),  32'(mown[i]));
      check({p, " out_data"},  32'(data_w[i]), 32'(rom_fn({mcode[i], ei})));
    end
  endtask

  task automatic model_sample();
    bit act, w;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      act = have[i] && (t - a_cyc[i] <= 7 + lat[i]);
      if (!act && (req0 || req1)) begin
        w        = (req0 && req1) ? !mlast[i] : req1;
        have[i]  = 1'b1;
        a_cyc[i] = t + 1;
        mown[i]  = w;
        mlast[i] = w;
        mcode[i] = w ? code1 : code0;
        $display("cycle %0d L%0d: grant req%0d code 0x%02h", t + 1, lat[i], w, mcode[i]);
      end
    end
  endtask

  task automatic cycle(input logic rs, input logic r0, input logic [7:0] c0,
                       input logic r1, input logic [7:0] c1);
    @(posedge clka);
    #1;
    t++;
    for (int i = 0; i < NI; i++) model_check(i);
    rst   = rs;
    req0  = r0;
    code0 = c0;
    req1  = r1;
    code1 = c1;
    model_sample();
  endtask

  task automatic mid_reset();
    string p;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      p = $sformatf("L%0d rst", lat[i]);
      check({p, " busy"},      32'(busy_w[i]), 32'd0);
      check({p, " gnt0"},      32'(gnt0_w[i]), 32'd0);
      check({p, " gnt1"},      32'(gnt1_w[i]), 32'd0);
      check({p, " out_valid"}, 32'(val_w[i]),  32'd0);
      check({p, " out_last"},  32'(last_w[i]), 32'd0);
    end
    model_reset();
  endtask

  initial begin
    logic       r0, r1;
    logic [7:0] c0, c1;
    string      p;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; code0 = 8'h00; code1 = 8'h00;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      p = $sformatf("L%0d reset", lat[i]);
      check({p, " busy"},      32'(busy_w[i]), 32'd0);
      check({p, " gnt0"},      32'(gnt0_w[i]), 32'd0);
      check({p, " gnt1"},      32'(gnt1_w[i]), 32'd0);
      check({p, " out_valid"}, 32'(val_w[i]),  32'd0);
      check({p, " out_last"},  32'(last_w[i]), 32'd0);
      check({p, " rom_addr"},  32'(addr_w[i]), 32'd0);
      check({p, " out_idx"},   32'(idx_w[i]),  32'd0);
      check({p, " out_owner"}, 32'(own_w[i]),  32'd0);
      check({p, " out_data"},  32'(data_w[i]), 32'd0);
    end

    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    // Single request from requester 0.
    cycle(1'b0, 1'b1, 8'h41, 1'b0, 8'h00);
    repeat (16) cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    // Both requesting continuously from reset release.
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    repeat (50) cycle(1'b0, 1'b1, 8'h10, 1'b1, 8'h20);

    // Requester 1 alone on the top code.
    repeat (36) cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'hFF);
    repeat (14) cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    // Requester 0 arrives while requester 1's burst runs.
    repeat (3)  cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h33);
    repeat (25) cycle(1'b0, 1'b1, 8'h44, 1'b1, 8'h33);
    repeat (14) cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    // Asynchronous reset after three bytes of a burst.
    cycle(1'b0, 1'b1, 8'h5C, 1'b0, 8'h00);
    while (t < a_cyc[0] + 3) cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    mid_reset();
    cycle(1'b1, 1'b1, 8'h5C, 1'b1, 8'h6D);
    repeat (30) cycle(1'b0, 1'b1, 8'h5C, 1'b1, 8'h6D);

    // Randomized requesters.
    r0 = 1'b0; r1 = 1'b0; c0 = 8'h00; c1 = 8'h00;
    repeat (2000) begin
      if (!r0) begin
        if ($urandom_range(2) == 0) begin
          r0 = 1'b1;
          c0 = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
        end
      end else if ($urandom_range(9) == 0) begin
        r0 = 1'b0;
      end
      if (!r1) begin
        if ($urandom_range(2) == 0) begin
          r1 = 1'b1;
          c1 = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
        end
      end else if ($urandom_range(9) == 0) begin
        r1 = 1'b0;
      end
      cycle(1'b0, r0, c0, r1, c1);
    end
    repeat (16) cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
